serial_magnitude_comparator: RTL and testbench

Multi-cycle magnitude comparator that scans two WIDTH-bit operands MSB-first, DIGIT bits per clock, in unsigned or two's-complement mode selected per operation. It returns mutually exclusive eq/gt/lt flags through a start/busy/done handshake. It can stop early at the first differing digit. It serves datapaths that need wide compares without a full-width combinational comparator, and it is the sequential successor to the team's 8-bit combinational unsigned/two's-complement comparators.

---
 rtl/serial_magnitude_comparator_pkg.sv | 20 ++
 rtl/serial_magnitude_comparator_digit.sv | 22 ++
 rtl/serial_magnitude_comparator.sv | 164 ++++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and elaboration helpers for the serial magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } cmp_state_t;

    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_GT,
        CMP_LT
    } cmp_result_t;

    // True when the operand splits into a whole number of non-empty digits.
    function automatic bit width_ok(input int unsigned width, input int unsigned digit);
        return (digit != 0) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_digit.sv
// Combinational DIGIT-bit comparator, unsigned or two's complement.
module digit_comparator #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             is_signed,
    output logic             eq,
    output logic             gt
);

    // Equality is mode-independent; ordering depends on the sign interpretation.
    always_comb begin
        eq = (a == b);
        if (is_signed) begin
            gt = ($signed(a) > $signed(b));
        end else begin
            gt = (a > b);
        end
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with start/busy/done handshake.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIGIT      = 1,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Reject digit sizes that leave a partial digit.
    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_digit
        $error("serial_magnitude_comparator: DIGIT must divide WIDTH");
    end

    cmp_state_t  state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             sgn_q, sgn_d;
    logic             decided_q, decided_d;
    cmp_result_t      res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic             dig_eq;
    logic             dig_gt;
    logic             last_digit;
    logic             finish;
    cmp_result_t      res_now;

    // Only the most significant digit carries the sign.
    digit_comparator #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a         (a_sh_q[WIDTH-1 -: DIGIT]),
        .b         (b_sh_q[WIDTH-1 -: DIGIT]),
        .is_signed (sgn_q && (cnt_q == '0)),
        .eq        (dig_eq),
        .gt        (dig_gt)
    );

    assign last_digit = (cnt_q == CW'(NDIG - 1));

    // Next-state and output logic: latch on start, scan digits, publish result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sgn_d     = sgn_q;
        decided_d = decided_q;
        res_d     = res_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        res_now   = res_q;
        finish    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    a_sh_d    = a;
                    b_sh_d    = b;
                    sgn_d     = signed_mode;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    res_d     = CMP_EQ;
                    busy_d    = 1'b1;
                end
            end

            RUN: begin
                // A result fixed by an earlier digit is never overridden.
                if (decided_q) begin
                    res_now = res_q;
                end else if (!dig_eq) begin
                    res_now = dig_gt ? CMP_GT : CMP_LT;
                end else begin
                    res_now = CMP_EQ;
                end

                finish = last_digit || (EARLY_EXIT && (res_now != CMP_EQ));

                if (finish) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    eq_d    = (res_now == CMP_EQ);
                    gt_d    = (res_now == CMP_GT);
                    lt_d    = (res_now == CMP_LT);
                end else begin
                    busy_d    = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    a_sh_d    = a_sh_q << DIGIT;
                    b_sh_d    = b_sh_q << DIGIT;
                    decided_d = (res_now != CMP_EQ);
                    res_d     = res_now;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sgn_q     <= 1'b0;
            decided_q <= 1'b0;
            res_q     <= CMP_EQ;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sgn_q     <= sgn_d;
            decided_q <= decided_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and model-checked bench for serial_magnitude_comparator.
module tb_serial_magnitude_comparator;

    logic clk = 1'b0;
    logic reset;

    // 8-bit, 1-bit digit, early exit
    logic       st8, sm8;
    logic [7:0] a8, b8;
    logic       busy8, done8, eq8, gt8, lt8;

    // 16-bit, 4-bit digit, with and without early exit, driven in parallel
    logic        st16, sm16;
    logic [15:0] a16, b16;
    logic        busy_e, done_e, eq_e, gt_e, lt_e;
    logic        busy_f, done_f, eq_f, gt_f, lt_f;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b1)) u_dut8 (
        .clk(clk), .reset(reset), .start(st8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
    );

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b1)) u_dut16e (
        .clk(clk), .reset(reset), .start(st16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy_e), .done(done_e), .eq(eq_e), .gt(gt_e), .lt(lt_e)
    );

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b0)) u_dut16f (
        .clk(clk), .reset(reset), .start(st16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy_f), .done(done_f), .eq(eq_f), .gt(gt_f), .lt(lt_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: digits up to and including the first differing nibble.
    function automatic int exp_n16(input logic [15:0] av, input logic [15:0] bv);
        for (int i = 0; i < 4; i++) begin
            if (av[15-4*i -: 4] != bv[15-4*i -: 4]) return i + 1;
        end
        return 4;
    endfunction

    // Reference flags {eq, gt, lt} from full-width arithmetic compare.
    function automatic logic [2:0] exp_fl16(input logic [15:0] av, input logic [15:0] bv, input logic smv);
        if (av == bv) return 3'b100;
        if (smv) return ($signed(av) > $signed(bv)) ? 3'b010 : 3'b001;
        return (av > bv) ? 3'b010 : 3'b001;
    endfunction

    // One 8-bit operation: returns digits processed (N) and flags at done.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic smv,
                       output int n, output logic [2:0] fl);
        @(negedge clk);
        a8 = av; b8 = bv; sm8 = smv; st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0; a8 = ~av; b8 = av;
        check("op8_busy", 32'(busy8), 32'd1);
        n = -1; fl = 3'b000;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                n = k; fl = {eq8, gt8, lt8};
                check("op8_busy_in_done", 32'(busy8), 32'd0);
                break;
            end
        end
    endtask

    // One 16-bit operation on both variants at once.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic smv,
                        output int ne, output int nf, output logic [2:0] fe, output logic [2:0] ff);
        @(negedge clk);
        a16 = av; b16 = bv; sm16 = smv; st16 = 1'b1;
        @(posedge clk);
        #1;
        st16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        ne = -1; nf = -1; fe = 3'b000; ff = 3'b000;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done_e && ne < 0) begin ne = k; fe = {eq_e, gt_e, lt_e}; end
            if (done_f && nf < 0) begin nf = k; ff = {eq_f, gt_f, lt_f}; end
            if (ne >= 0 && nf >= 0) break;
        end
    endtask

    initial begin
        int          n, ne, nf, hits;
        logic [2:0]  fl, fe, ff;
        logic [15:0] ra, rb;
        logic        rs;

        reset = 1'b0;
        st8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        st16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs8", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
        check("reset_outs16", 32'({busy_e, done_e, eq_e, gt_e, lt_e, busy_f, done_f, eq_f, gt_f, lt_f}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Unsigned MSB split
        op8(8'h80, 8'h7F, 1'b0, n, fl);
        check("t1_flags", 32'(fl), 32'(3'b010));
        check("t1_n", n, 1);

        // Signed MSB split, then sign-equal case resolved at LSB
        op8(8'h80, 8'h7F, 1'b1, n, fl);
        check("t2a_flags", 32'(fl), 32'(3'b001));
        check("t2a_n", n, 1);
        op8(8'hFF, 8'hFE, 1'b1, n, fl);
        check("t2b_flags", 32'(fl), 32'(3'b010));
        check("t2b_n", n, 8);

        // Equality in both modes; done is a single-cycle pulse
        op8(8'hA5, 8'hA5, 1'b0, n, fl);
        check("t3u_flags", 32'(fl), 32'(3'b100));
        check("t3u_n", n, 8);
        @(posedge clk);
        #1;
        check("t3_done_pulse", 32'(done8), 32'd0);
        check("t3_flags_hold", 32'({eq8, gt8, lt8}), 32'(3'b100));
        op8(8'hA5, 8'hA5, 1'b1, n, fl);
        check("t3s_flags", 32'(fl), 32'(3'b100));
        check("t3s_n", n, 8);

        // Back-to-back with start held through RUN
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h04; sm8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1;
        a8 = 8'h00; b8 = 8'hFF;
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin n = k; break; end
        end
        check("t4a_n", n, 8);
        check("t4a_flags", 32'({eq8, gt8, lt8}), 32'(3'b010));
        a8 = 8'h01; b8 = 8'h02;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        check("t4b_accept", 32'({busy8, done8}), 32'(2'b10));
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin n = k; break; end
        end
        check("t4b_n", n, 7);
        check("t4b_flags", 32'({eq8, gt8, lt8}), 32'(3'b001));

        // Reset in the 4th RUN cycle
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h0E; sm8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("t5_busy_before", 32'(busy8), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_outs_cleared", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) hits++;
        end
        check("t5_no_done", hits, 0);
        op8(8'h10, 8'h20, 1'b0, n, fl);
        check("t5_after_flags", 32'(fl), 32'(3'b001));
        check("t5_after_n", n, 3);

        // 16-bit, 4-bit digits, directed
        op16(16'h1234, 16'h1243, 1'b0, ne, nf, fe, ff);
        check("t6a_flags_e", 32'(fe), 32'(3'b001));
        check("t6a_n_e", ne, 3);
        check("t6a_flags_f", 32'(ff), 32'(3'b001));
        check("t6a_n_f", nf, 4);
        op16(16'h8000, 16'h7FFF, 1'b1, ne, nf, fe, ff);
        check("t6b_flags_e", 32'(fe), 32'(3'b001));
        check("t6b_n_e", ne, 1);
        check("t6b_flags_f", 32'(ff), 32'(3'b001));
        op16(16'h8000, 16'h7FFF, 1'b0, ne, nf, fe, ff);
        check("t6c_flags_e", 32'(fe), 32'(3'b010));
        check("t6c_n_f", nf, 4);

        // 16-bit random against arithmetic reference
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = ra;
                2: rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                default: rb = ra ^ 16'($urandom_range(1, 15));
            endcase
            rs = 1'($urandom_range(0, 1));
            op16(ra, rb, rs, ne, nf, fe, ff);
            check("rnd_flags_e", 32'(fe), 32'(exp_fl16(ra, rb, rs)));
            check("rnd_flags_f", 32'(ff), 32'(exp_fl16(ra, rb, rs)));
            check("rnd_n_e", ne, exp_n16(ra, rb));
            check("rnd_n_f", nf, 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
